// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the CPU run/halt/step controller.
// Simulation builds under __ICARUS__ shorten the debounce window.
package cpu_ctrl_pkg;

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

`ifdef __ICARUS__
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
`else
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
`endif

  localparam int unsigned COUNT_W_DEF = 32;
  localparam int unsigned PC_W        = 32;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer; emits a one-cycle pulse on each
// accepted press. Releases are filtered the same way but produce no pulse.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic btn_in,
  output logic press_out
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = r_sync[1] ^ r_stable;
  assign w_accept = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Counter runs only while the synced input disagrees; any agreement restarts it.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_in};
      r_press <= w_accept && r_sync[1];
      if (w_accept) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press_out = r_press;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the divided slow clock into a one-cycle CPU enable with run/halt/step
// control and an issued-cycle counter. Optional breakpoint: CPU_STEP_BREAKPOINT_EN.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned COUNT_W         = COUNT_W_DEF
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               slow_clk_in,
  input  logic               run_sw_in,
  input  logic               step_btn_in,
`ifdef CPU_STEP_BREAKPOINT_EN
  input  logic [PC_W-1:0]    pc_in,
  input  logic [PC_W-1:0]    bp_addr_in,
  input  logic               bp_valid_in,
  output logic               bp_hit_out,
`endif
  output logic               cpu_en_out,
  output logic               halted_out,
  output logic [COUNT_W-1:0] cycle_count_out
);

  logic               r_slow_q;
  logic [1:0]         r_state;
  logic               r_cpu_en;
  logic               r_halted;
  logic [COUNT_W-1:0] r_count;
  logic               w_tick;
  logic               w_press;
  logic [1:0]         w_state_nxt;
  logic               w_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .btn_in   (step_btn_in),
    .press_out(w_press)
  );

  assign w_tick = slow_clk_in & ~r_slow_q;

`ifdef CPU_STEP_BREAKPOINT_EN
  logic r_bp_hit;
  logic r_armed;
  logic w_bp_match;

  assign w_bp_match = bp_valid_in && (pc_in == bp_addr_in);
`endif

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) r_state <= ST_HALT;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = 1'b0;
    case (r_state)
      ST_HALT: begin
`ifdef CPU_STEP_BREAKPOINT_EN
        if (run_sw_in && (!r_bp_hit || r_armed)) w_state_nxt = ST_RUN;
`else
        if (run_sw_in)                           w_state_nxt = ST_RUN;
`endif
        else if (w_press)                        w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        // Dropping the run switch wins over a coincident tick.
        if (!run_sw_in) begin
          w_state_nxt = ST_HALT;
`ifdef CPU_STEP_BREAKPOINT_EN
        end else if (w_tick && w_bp_match) begin
          w_state_nxt = ST_HALT;
`endif
        end else if (w_tick) begin
          w_pulse = 1'b1;
        end
      end
      ST_STEP: begin
        if (w_tick) begin
          w_pulse     = 1'b1;
          w_state_nxt = ST_HALT;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // Registered outputs: enable, halted flag and issued-cycle counter.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_slow_q <= 1'b0;
      r_cpu_en <= 1'b0;
      r_halted <= 1'b1;
      r_count  <= '0;
    end else begin
      r_slow_q <= slow_clk_in;
      r_cpu_en <= w_pulse;
      r_halted <= (w_state_nxt == ST_HALT);
      if (w_pulse) r_count <= r_count + COUNT_W'(1);
    end
  end

`ifdef CPU_STEP_BREAKPOINT_EN
  // Sticky hit flag; after a hit the run switch must be seen low before RUN resumes.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_bp_hit <= 1'b0;
      r_armed  <= 1'b1;
    end else begin
      if (!run_sw_in) r_armed <= 1'b1;
      if ((r_state == ST_RUN) && run_sw_in && w_tick && w_bp_match) begin
        r_bp_hit <= 1'b1;
        r_armed  <= 1'b0;
      end else if ((r_state == ST_HALT) && (w_state_nxt == ST_STEP)) begin
        r_bp_hit <= 1'b0;
      end
    end
  end

  assign bp_hit_out = r_bp_hit;
`endif

  assign cpu_en_out      = r_cpu_en;
  assign halted_out      = r_halted;
  assign cycle_count_out = r_count;

endmodule
